// File: rtl/mem_access_stage.sv
// mem_access_stage: accepts one load/store per handshake, decodes BRAM/MMIO regions, drives lane strobes
// and holds a registered response aligned with BRAM read latency. Define MEM_ALIGN_TRAP_EN to fault misaligned accesses.
module mem_access_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_op,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        ram_en,
  output logic [3:0]  ram_we,
  output logic        buf_en,
  output logic [3:0]  buf_we,
  output logic [31:0] bram_addr,
  output logic [31:0] bram_wdata,
  output logic        din_rd,
  output logic [31:0] dout_reg,
  output logic        dout_wr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_addr,
  output logic [1:0]  rsp_op,
  output logic [1:0]  rsp_size,
  output logic        rsp_fault
);

  localparam logic [1:0] MEM_DISABLE   = 2'b00;
  localparam logic [1:0] MEM_READ_SEXT = 2'b01;
  localparam logic [1:0] MEM_READ_ZEXT = 2'b10;
  localparam logic [1:0] MEM_WRITE     = 2'b11;

  localparam logic [1:0] BYTE     = 2'b00;
  localparam logic [1:0] HALFWORD = 2'b01;
  localparam logic [1:0] WORD     = 2'b10;

  localparam logic [31:0] CPU_BRAM_END   = 32'h007F_FF00;
  localparam logic [31:0] BUF_BRAM_START = 32'h0100_0000;
  localparam logic [31:0] BUF_BRAM_END   = 32'h013F_FF00;
  localparam logic [31:0] DIN_REG        = 32'h0200_0000;
  localparam logic [31:0] DOUT_REG       = 32'h0200_0100;

  typedef enum logic {IDLE, RESP} state_t;

  state_t      state, state_next;
  logic        accept;
  logic        in_cpu, in_buf, in_din, in_dout;
  logic        is_rd, is_wr;
  logic        misaligned;
  logic        fault;
  logic [1:0]  offset;
  logic [3:0]  lane_we;
  logic [31:0] lane_wdata;

  logic [31:0] rsp_addr_p1;
  logic [1:0]  rsp_op_p1;
  logic [1:0]  rsp_size_p1;
  logic        rsp_fault_p1;
  logic [31:0] dout_p1;
  logic        dout_wr_p1;

  // Halfwords snap to offset 0/2, words to offset 0, when misalignment is not trapped.
  function automatic logic [1:0] eff_offset(input logic [1:0] size, input logic [1:0] off);
    case (size)
      HALFWORD: eff_offset = {off[1], 1'b0};
      WORD:     eff_offset = 2'b00;
      default:  eff_offset = off;
    endcase
  endfunction

  function automatic logic [3:0] lane_strobe(input logic [1:0] size, input logic [1:0] off);
    case (size)
      BYTE:     lane_strobe = 4'b1000 >> off;
      HALFWORD: lane_strobe = off[1] ? 4'b0011 : 4'b1100;
      WORD:     lane_strobe = 4'b1111;
      default:  lane_strobe = 4'b0000;
    endcase
  endfunction

  // Lane 0 sits in bits [31:24]; store bytes land little-endian starting at the offset lane.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [1:0] off,
                                            input logic [31:0] wdata);
    case (size)
      BYTE:     lane_data = {wdata[7:0], 24'h0} >> {off, 3'b000};
      HALFWORD: lane_data = off[1] ? {16'h0, wdata[7:0], wdata[15:8]}
                                   : {wdata[7:0], wdata[15:8], 16'h0};
      WORD:     lane_data = {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]};
      default:  lane_data = 32'h0;
    endcase
  endfunction

  assign req_ready = reset && ((state == IDLE) || rsp_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    in_cpu     = (req_addr <= CPU_BRAM_END);
    in_buf     = (req_addr >= BUF_BRAM_START) && (req_addr <= BUF_BRAM_END);
    in_din     = (req_addr == DIN_REG);
    in_dout    = (req_addr == DOUT_REG);
    is_rd      = (req_op == MEM_READ_SEXT) || (req_op == MEM_READ_ZEXT);
    is_wr      = (req_op == MEM_WRITE);
    misaligned = ((req_size == HALFWORD) && req_addr[0]) ||
                 ((req_size == WORD) && (req_addr[1:0] != 2'b00));
    fault      = (req_op == MEM_DISABLE) || (req_size == 2'b11) ||
                 !(in_cpu || in_buf || in_din || in_dout) ||
                 (in_dout && is_rd) || (in_din && is_wr);
`ifdef MEM_ALIGN_TRAP_EN
    fault      = fault || misaligned;
`endif
    offset     = eff_offset(req_size, req_addr[1:0]);
    lane_we    = lane_strobe(req_size, offset);
    lane_wdata = lane_data(req_size, offset, req_wdata);
  end

  assign bram_addr  = {req_addr[31:2], 2'b00};
  assign bram_wdata = lane_wdata;

  always_comb begin
    ram_en = 1'b0;
    buf_en = 1'b0;
    din_rd = 1'b0;
    ram_we = 4'b0000;
    buf_we = 4'b0000;
    if (accept && !fault) begin
      ram_en = in_cpu;
      buf_en = in_buf;
      din_rd = in_din && is_rd;
      if (is_wr) begin
        ram_we = in_cpu ? lane_we : 4'b0000;
        buf_we = in_buf ? lane_we : 4'b0000;
      end
    end
  end

  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = RESP;
    end else if ((state == RESP) && rsp_ready) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Stage p1: response captured at accept, valid alongside BRAM/DIN read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_addr_p1  <= 32'h0;
      rsp_op_p1    <= MEM_DISABLE;
      rsp_size_p1  <= BYTE;
      rsp_fault_p1 <= 1'b0;
      dout_p1      <= 32'h0;
      dout_wr_p1   <= 1'b0;
    end else begin
      dout_wr_p1 <= accept && !fault && in_dout && is_wr;
      if (accept) begin
        rsp_addr_p1  <= req_addr;
        rsp_op_p1    <= req_op;
        rsp_size_p1  <= req_size;
        rsp_fault_p1 <= fault;
        if (!fault && in_dout && is_wr) begin
          dout_p1 <= req_wdata;
        end
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_addr  = rsp_addr_p1;
  assign rsp_op    = rsp_op_p1;
  assign rsp_size  = rsp_size_p1;
  assign rsp_fault = rsp_fault_p1;
  assign dout_reg  = dout_p1;
  assign dout_wr   = dout_wr_p1;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed steps then random traffic against a byte-level reference model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_op;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic        buf_en;
  logic [3:0]  buf_we;
  logic [31:0] bram_addr;
  logic [31:0] bram_wdata;
  logic        din_rd;
  logic [31:0] dout_reg;
  logic        dout_wr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_addr;
  logic [1:0]  rsp_op;
  logic [1:0]  rsp_size;
  logic        rsp_fault;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic        m_pend = 1'b0;
  logic [31:0] m_addr = 32'h0;
  logic [1:0]  m_op = 2'b00;
  logic [1:0]  m_size = 2'b00;
  logic        m_fault = 1'b0;
  logic [31:0] m_dout = 32'h0;
  logic        m_dout_wr = 1'b0;

  mem_access_stage dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_op(req_op), .req_size(req_size), .req_wdata(req_wdata),
    .ram_en(ram_en), .ram_we(ram_we), .buf_en(buf_en), .buf_we(buf_we),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata), .din_rd(din_rd),
    .dout_reg(dout_reg), .dout_wr(dout_wr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_addr(rsp_addr), .rsp_op(rsp_op), .rsp_size(rsp_size), .rsp_fault(rsp_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected effect of one request, derived byte by byte from the memory-map rules.
  task automatic model(input logic [31:0] a, input logic [1:0] op, input logic [1:0] sz,
                       input logic [31:0] wd, output logic flt, output logic e_ram,
                       output logic e_buf, output logic e_din, output logic [3:0] we,
                       output logic [31:0] data, output logic [31:0] mask, output logic dwr);
    logic rd, wr, cpu, bufr, din, dout, misal;
    int nbytes, off, lane;
    rd = (op == 2'd1) || (op == 2'd2);
    wr = (op == 2'd3);
    cpu = (a <= 32'h007F_FF00);
    bufr = (a >= 32'h0100_0000) && (a <= 32'h013F_FF00);
    din = (a == 32'h0200_0000);
    dout = (a == 32'h0200_0100);
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    off = int'(a[1:0]);
    misal = (nbytes > 0) && ((off % nbytes) != 0);
    flt = !(rd || wr) || (nbytes == 0) || !(cpu || bufr || din || dout) ||
          (dout && rd) || (din && wr);
`ifdef MEM_ALIGN_TRAP_EN
    flt = flt || misal;
`else
    if (misal) off = off - (off % nbytes);
`endif
    e_ram = !flt && cpu;
    e_buf = !flt && bufr;
    e_din = !flt && din && rd;
    dwr = !flt && dout && wr;
    we = 4'h0;
    data = 32'h0;
    mask = 32'h0;
    if (!flt && wr && (cpu || bufr)) begin
      for (int i = 0; i < nbytes; i++) begin
        lane = off + i;
        we[3 - lane] = 1'b1;
        data[31 - 8 * lane -: 8] = wd[8 * i +: 8];
        mask[31 - 8 * lane -: 8] = 8'hFF;
      end
    end
  endtask

  // One clock: drive at negedge, check strobes before the edge, check registered state after it.
  task automatic step(input logic v, input logic [31:0] a, input logic [1:0] op,
                      input logic [1:0] sz, input logic [31:0] wd, input logic rr);
    logic flt, e_ram, e_buf, e_din, dwr, acc;
    logic [3:0] we;
    logic [31:0] data, mask;
    @(negedge clk);
    req_valid = v; req_addr = a; req_op = op; req_size = sz; req_wdata = wd; rsp_ready = rr;
    model(a, op, sz, wd, flt, e_ram, e_buf, e_din, we, data, mask, dwr);
    acc = v && (!m_pend || rr);
    #1;
    check("req_ready", req_ready, !m_pend || rr);
    check("ram_en", ram_en, acc && e_ram);
    check("buf_en", buf_en, acc && e_buf);
    check("din_rd", din_rd, acc && e_din);
    check("ram_we", ram_we, (acc && e_ram) ? we : 4'h0);
    check("buf_we", buf_we, (acc && e_buf) ? we : 4'h0);
    if (acc) check("bram_addr", bram_addr, {a[31:2], 2'b00});
    if (acc && (we != 4'h0)) check("bram_wdata", bram_wdata & mask, data);
    @(posedge clk);
    if (acc) begin
      m_pend = 1'b1; m_addr = a; m_op = op; m_size = sz; m_fault = flt;
      if (dwr) m_dout = wd;
    end else if (rr) begin
      m_pend = 1'b0;
    end
    m_dout_wr = acc && dwr;
    #1;
    check("rsp_valid", rsp_valid, m_pend);
    check("dout_reg", dout_reg, m_dout);
    check("dout_wr", dout_wr, m_dout_wr);
    if (m_pend) begin
      check("rsp_addr", rsp_addr, m_addr);
      check("rsp_op", rsp_op, m_op);
      check("rsp_size", rsp_size, m_size);
      check("rsp_fault", rsp_fault, m_fault);
    end
  endtask

  task automatic check_reset_state();
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_addr", rsp_addr, 32'h0);
    check("rst_rsp_op", rsp_op, 2'b00);
    check("rst_rsp_size", rsp_size, 2'b00);
    check("rst_rsp_fault", rsp_fault, 1'b0);
    check("rst_dout_reg", dout_reg, 32'h0);
    check("rst_dout_wr", dout_wr, 1'b0);
    check("rst_ram_en", ram_en, 1'b0);
    check("rst_ram_we", ram_we, 4'h0);
    check("rst_buf_en", buf_en, 1'b0);
    check("rst_din_rd", din_rd, 1'b0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 6))
      0: a = $urandom_range(0, 32'h007F_FF00);
      1: a = 32'h007F_FEFC + $urandom_range(0, 8);
      2: a = 32'h0100_0000 + $urandom_range(0, 32'h003F_FF00);
      3: a = 32'h013F_FEFC + $urandom_range(0, 8);
      4: a = 32'h0200_0000 + (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      5: a = 32'h0200_0100 + (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      default: a = $urandom;
    endcase
    return a;
  endfunction

  initial begin
    reset = 1'b0;
    req_valid = 1'b1; req_addr = 32'h10; req_op = 2'b11; req_size = 2'b10;
    req_wdata = 32'h1234_5678; rsp_ready = 1'b1;
    #2;
    check_reset_state();
    @(negedge clk);
    reset = 1'b1;

    // SW to CPU BRAM
    step(1'b1, 32'h0000_0010, 2'b11, 2'b10, 32'h1122_3344, 1'b1);
    // SB then SH into buffer BRAM
    step(1'b1, 32'h0100_0003, 2'b11, 2'b00, 32'h0000_00A5, 1'b1);
    step(1'b1, 32'h0100_0002, 2'b11, 2'b01, 32'h0000_BEEF, 1'b1);
    step(1'b0, 32'h0, 2'b00, 2'b00, 32'h0, 1'b1);
    // LW from DIN with a 3-cycle response stall
    step(1'b1, 32'h0200_0000, 2'b01, 2'b10, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h0000_0020, 2'b01, 2'b10, 32'h0, 1'b0);
    step(1'b0, 32'h0, 2'b00, 2'b00, 32'h0, 1'b1);
    // DOUT write then faulting DOUT read
    step(1'b1, 32'h0200_0100, 2'b11, 2'b10, 32'hDEAD_BEEF, 1'b1);
    step(1'b1, 32'h0200_0100, 2'b01, 2'b10, 32'h0, 1'b1);
    // Back-to-back byte loads
    step(1'b1, 32'h4, 2'b01, 2'b00, 32'h0, 1'b1);
    step(1'b1, 32'h5, 2'b01, 2'b00, 32'h0, 1'b1);
    step(1'b1, 32'h6, 2'b10, 2'b00, 32'h0, 1'b1);
    // Misaligned halfword, and the other fault classes
    step(1'b1, 32'h1, 2'b01, 2'b01, 32'h0, 1'b1);
    step(1'b1, 32'h0200_0000, 2'b11, 2'b10, 32'h5555_5555, 1'b1);
    step(1'b1, 32'h0000_0008, 2'b01, 2'b11, 32'h0, 1'b1);
    step(1'b1, 32'h0000_0008, 2'b00, 2'b10, 32'h0, 1'b1);
    step(1'b1, 32'h0080_0000, 2'b01, 2'b10, 32'h0, 1'b1);
    step(1'b1, 32'h0000_0007, 2'b11, 2'b10, 32'hCAFE_F00D, 1'b1);

    // Reset in the middle of a response with a dout_wr pulse showing
    step(1'b1, 32'h0200_0100, 2'b11, 2'b00, 32'h0BAD_CAFE, 1'b0);
    reset = 1'b0;
    req_valid = 1'b1; req_addr = 32'h10; req_op = 2'b01; req_size = 2'b10; rsp_ready = 1'b1;
    #1;
    m_pend = 1'b0; m_dout = 32'h0; m_dout_wr = 1'b0;
    check_reset_state();
    @(negedge clk);
    reset = 1'b1;

    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 4) != 0), rand_addr(), 2'($urandom_range(0, 3)),
           (($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2))),
           $urandom, ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
